// File: rtl/cordic_arb_pkg.sv
// Shared types for the CORDIC arbiter: the tag carried alongside the core and the buffered result.
// No logic of its own; only the ID-width helper and the packed structs.
// Widths follow the default arbiter build (16-bit operands, 4 requesters).
package cordic_arb_pkg;

  // Bits needed to name one of n items, never narrower than one bit
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CA_BIT_WIDTH = 16;
  localparam int CA_NUM_REQ   = 4;
  localparam int CA_ID_W      = id_width(CA_NUM_REQ);

  typedef struct packed {
    logic               valid;
    logic [CA_ID_W-1:0] id;
  } tag_t;

  typedef struct packed {
    logic [CA_ID_W-1:0]      id;
    logic [CA_BIT_WIDTH-1:0] angle;
    logic [CA_BIT_WIDTH-1:0] x;
    logic [CA_BIT_WIDTH-1:0] y;
  } result_t;

endpackage

// File: rtl/cordic_result_fifo.sv
// Result buffer: first-word fall-through FIFO with registered storage and an occupancy count.
// Latency: a write is visible at the head the cycle after it is taken.
// Backpressure: head held while i_rd_rdy is low; write and pop in one cycle are both honoured.
module cordic_result_fifo
  import cordic_arb_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = result_t
) (
  input  logic clk,
  input  logic reset,
  input  logic i_wr_vld,
  input  T     i_wr_dat,
  output logic o_rd_vld,
  input  logic i_rd_rdy,
  output T     o_rd_dat
);

  localparam int PW = id_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  // Pointer advance with explicit wrap so non-power-of-two depths work
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_rd_vld = (r_count != '0);
  assign w_pop    = o_rd_vld & i_rd_rdy;
  // A full buffer still takes a write when the head leaves in the same cycle
  assign w_push   = i_wr_vld & ((r_count != CW'(DEPTH)) | w_pop);
  // Data reads as zero while empty so the outputs are clean after reset
  assign o_rd_dat = o_rd_vld ? r_mem[r_rd_ptr] : '0;

  // Storage write; contents are don't-care until counted valid
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_dat;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one pipelined CORDIC core among NUM_REQ requesters and returns tagged results in order.
// Latency: accept at t -> core_start at t+1 -> rsp_valid at t+2+LATENCY.
// Backpressure: grants stop once FIFO_DEPTH results are outstanding; rsp_ready low never drops data.
// Build option CORDIC_ARB_RR_EN: round-robin arbitration; otherwise fixed priority (lowest index wins).
module cordic_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int BIT_WIDTH  = CA_BIT_WIDTH,
  parameter int NUM_REQ    = CA_NUM_REQ,
  parameter int LATENCY    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_angle,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_x,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_y,
  input  logic [NUM_REQ-1:0]           req_mode,
  output logic                         core_start,
  output logic [BIT_WIDTH-1:0]         core_angle,
  output logic [BIT_WIDTH-1:0]         core_x,
  output logic [BIT_WIDTH-1:0]         core_y,
  output logic                         core_mode,
  input  logic                         core_done,
  input  logic [BIT_WIDTH-1:0]         core_out_angle,
  input  logic [BIT_WIDTH-1:0]         core_out_x,
  input  logic [BIT_WIDTH-1:0]         core_out_y,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [BIT_WIDTH-1:0]         rsp_angle,
  output logic [BIT_WIDTH-1:0]         rsp_x,
  output logic [BIT_WIDTH-1:0]         rsp_y,
  output logic                         err
);

  localparam int ID_W = id_width(NUM_REQ);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  // Arbitration / issue
  logic [NUM_REQ-1:0]   w_grant;
  logic [ID_W-1:0]      w_grant_id;
  logic [ID_W-1:0]      w_idx;
  logic                 w_found;
  logic                 w_can_grant;
  logic                 w_accept;
  logic [BIT_WIDTH-1:0] w_sel_angle;
  logic [BIT_WIDTH-1:0] w_sel_x;
  logic [BIT_WIDTH-1:0] w_sel_y;
  logic                 w_sel_mode;

  logic                 r_core_start;
  logic [BIT_WIDTH-1:0] r_core_angle;
  logic [BIT_WIDTH-1:0] r_core_x;
  logic [BIT_WIDTH-1:0] r_core_y;
  logic                 r_core_mode;
  logic [ID_W-1:0]      r_issue_id;
  logic [CW-1:0]        r_outstanding;
  logic                 r_err;

  // Tag pipeline and result path
  tag_t                 r_tag [LATENCY];
  tag_t                 w_tag_in;
  tag_t                 w_tail;
  result_t              w_wr_dat;
  result_t              w_head;
  logic                 w_wr_vld;
  logic                 w_pop;

`ifdef CORDIC_ARB_RR_EN
  logic [ID_W-1:0]      r_ptr;
`endif

  // The credit is registered: a pop only frees a grant in the following cycle
  assign w_can_grant = !reset && (r_outstanding < CW'(FIFO_DEPTH));

  // Pick at most one valid requester, scanning from the priority start point
  always_comb begin
    w_grant    = '0;
    w_grant_id = '0;
    w_found    = 1'b0;
    w_idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef CORDIC_ARB_RR_EN
      w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
`else
      w_idx = ID_W'(k);
`endif
      if (!w_found && w_can_grant && req_valid[w_idx]) begin
        w_found        = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_grant_id     = w_idx;
      end
    end
  end

  assign req_ready = w_grant;
  assign w_accept  = w_found;

  // One-hot AND-OR mux of the granted requester's operands
  always_comb begin
    w_sel_angle = '0;
    w_sel_x     = '0;
    w_sel_y     = '0;
    w_sel_mode  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_angle = req_angle[i*BIT_WIDTH +: BIT_WIDTH];
        w_sel_x     = req_x[i*BIT_WIDTH +: BIT_WIDTH];
        w_sel_y     = req_y[i*BIT_WIDTH +: BIT_WIDTH];
        w_sel_mode  = req_mode[i];
      end
    end
  end

  // Register the accepted operation onto the core; data holds between starts
  always_ff @(posedge clk) begin
    if (reset) begin
      r_core_start <= 1'b0;
      r_core_angle <= '0;
      r_core_x     <= '0;
      r_core_y     <= '0;
      r_core_mode  <= 1'b0;
      r_issue_id   <= '0;
    end else begin
      r_core_start <= w_accept;
      if (w_accept) begin
        r_core_angle <= w_sel_angle;
        r_core_x     <= w_sel_x;
        r_core_y     <= w_sel_y;
        r_core_mode  <= w_sel_mode;
        r_issue_id   <= w_grant_id;
      end
    end
  end

  assign core_start = r_core_start;
  assign core_angle = r_core_angle;
  assign core_x     = r_core_x;
  assign core_y     = r_core_y;
  assign core_mode  = r_core_mode;

`ifdef CORDIC_ARB_RR_EN
  // Rotate priority to the requester just after the one granted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= ID_W'((int'(w_grant_id) + 1) % NUM_REQ);
    end
  end
`endif

  assign w_pop = rsp_valid & rsp_ready;

  // Outstanding = accepted but not yet popped; bounds in-flight work to the buffer size
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outstanding <= '0;
    end else if (w_accept && !w_pop) begin
      r_outstanding <= r_outstanding + 1'b1;
    end else if (!w_accept && w_pop && (r_outstanding != '0)) begin
      r_outstanding <= r_outstanding - 1'b1;
    end
  end

  assign w_tag_in.valid = r_core_start;
  assign w_tag_in.id    = r_issue_id;
  assign w_tail         = r_tag[LATENCY-1];

  // Tag shift register mirrors the core pipeline so the tail lines up with core_done
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // Only a done that matches a live tag is buffered; stray dones are dropped
  assign w_wr_vld       = w_tail.valid & core_done;
  assign w_wr_dat.id    = w_tail.id;
  assign w_wr_dat.angle = core_out_angle;
  assign w_wr_dat.x     = core_out_x;
  assign w_wr_dat.y     = core_out_y;

  // Sticky flag for any disagreement between the tag tail and core_done
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (core_done != w_tail.valid) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;

  cordic_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (result_t)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .i_wr_vld (w_wr_vld),
    .i_wr_dat (w_wr_dat),
    .o_rd_vld (rsp_valid),
    .i_rd_rdy (rsp_ready),
    .o_rd_dat (w_head)
  );

  assign rsp_id    = w_head.id;
  assign rsp_angle = w_head.angle;
  assign rsp_x     = w_head.x;
  assign rsp_y     = w_head.y;

endmodule
